// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 8-bit CPU control unit: opcodes, ALU codes,
// register codes, sequencer state encoding and instruction field positions.
package cpu_sequencer_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_ADDC = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_SUBC = 4'h4;
   localparam logic [3:0] OP_NAND = 4'h5;
   localparam logic [3:0] OP_NOR  = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_XNOR = 4'h8;
   localparam logic [3:0] OP_LDI  = 4'h9;
   localparam logic [3:0] OP_LD   = 4'hA;
   localparam logic [3:0] OP_ST   = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_JZ   = 4'hD;
   localparam logic [3:0] OP_JC   = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_ADDC = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_SUBC = 3'd3;
   localparam logic [2:0] ALU_NAND = 3'd4;
   localparam logic [2:0] ALU_NOR  = 3'd5;
   localparam logic [2:0] ALU_XOR  = 3'd6;
   localparam logic [2:0] ALU_XNOR = 3'd7;

   localparam logic [1:0] R0 = 2'd0;
   localparam logic [1:0] R1 = 2'd1;
   localparam logic [1:0] R2 = 2'd2;
   localparam logic [1:0] R3 = 2'd3;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RK_MSB  = 11;
   localparam int RK_LSB  = 10;
   localparam int RI_MSB  = 9;
   localparam int RI_LSB  = 8;
   localparam int RJ_MSB  = 7;
   localparam int RJ_LSB  = 6;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_FAULT
   } state_t;

   typedef struct packed {
      logic is_alu;
      logic is_ldi;
      logic is_ld;
      logic is_st;
      logic is_jmp;
      logic is_jz;
      logic is_jc;
      logic is_halt;
   } op_class_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Program-memory fetch port and data-RAM port of the CPU sequencer.
// Handshake: req is held high until the cycle in which ack is high; that cycle
// completes the transfer (data valid with ack). An ack while req is low is ignored.
interface cpu_sequencer_if;
   logic        instr_req;
   logic        instr_ack;
   logic [15:0] instr_data;
   logic        ram_req;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        ram_ack;

   modport master (
      output instr_req, ram_req, ram_we, ram_addr, ram_wdata,
      input  instr_ack, instr_data, ram_rdata, ram_ack
   );

   modport slave (
      input  instr_req, ram_req, ram_we, ram_addr, ram_wdata,
      output instr_ack, instr_data, ram_rdata, ram_ack
   );
endinterface

// File: rtl/cpu_seq_decode.sv
// Combinational instruction decode: register selects, ALU op, immediate and
// instruction class flags.
module cpu_seq_decode
   import cpu_sequencer_pkg::*;
(
   input  logic [15:0] instr,
   output logic [4:0]  ri_select,
   output logic [4:0]  rj_select,
   output logic [4:0]  rk_select,
   output logic [2:0]  alusel,
   output logic [7:0]  imm,
   output op_class_t   cls
);
   logic [3:0] op;
   logic [3:0] op_m1;

   always_comb begin
      op        = instr[OP_MSB:OP_LSB];
      op_m1     = op - 4'd1;
      imm       = instr[IMM_MSB:IMM_LSB];
      cls       = '0;
      alusel    = ALU_ADD;
      rk_select = {3'b000, instr[RK_MSB:RK_LSB]};
      ri_select = {3'b000, instr[RI_MSB:RI_LSB]};
      rj_select = {3'b000, instr[RJ_MSB:RJ_LSB]};
      case (op)
         OP_NOP:  ;
         OP_LDI:  cls.is_ldi = 1'b1;
         OP_LD:   cls.is_ld  = 1'b1;
         // Store data leaves through the ri read port, so ri must address rk.
         OP_ST: begin
            cls.is_st = 1'b1;
            ri_select = {3'b000, instr[RK_MSB:RK_LSB]};
         end
         OP_JMP:  cls.is_jmp  = 1'b1;
         OP_JZ:   cls.is_jz   = 1'b1;
         OP_JC:   cls.is_jc   = 1'b1;
         OP_HALT: cls.is_halt = 1'b1;
         default: begin
            cls.is_alu = 1'b1;
            alusel     = op_m1[2:0];
         end
      endcase
   end
endmodule

// File: rtl/cpu_sequencer.sv
// CPU control unit: fetch/decode/execute FSM, PC, carry/zero flags.
// Optional bus watchdog enabled by defining CPU_SEQ_WDOG_EN.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int WDOG_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   output logic [PC_W-1:0] pc,
   cpu_sequencer_if.master bus,
   output logic [4:0]      ri_select,
   output logic [4:0]      rj_select,
   output logic [4:0]      rk_select,
   output logic            update,
   output logic            wb_sel,
   output logic [7:0]      wb_imm,
   output logic [2:0]      alusel,
   output logic            carry,
   input  logic            alu_c,
   input  logic            alu_c_upd,
   input  logic            alu_zero,
   input  logic [7:0]      ri_data,
   output logic            halted,
   output logic            fault,
   output state_t          state_dbg
);
   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     instr_q, instr_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            carry_q, carry_d;
   logic            zero_q, zero_d;
   logic [7:0]      imm;
   op_class_t       cls;
   logic            taken;
   logic            ack_now;
   state_t          next_instr;

   cpu_seq_decode u_decode (
      .instr     (instr_q),
      .ri_select (ri_select),
      .rj_select (rj_select),
      .rk_select (rk_select),
      .alusel    (alusel),
      .imm       (imm),
      .cls       (cls)
   );

`ifdef CPU_SEQ_WDOG_EN
   logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
   logic [31:0] unused_wdog_w;
   assign unused_wdog_w = 32'(WDOG_W);
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      rdata_d    = rdata_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      taken      = cls.is_jmp || (cls.is_jz && zero_q) || (cls.is_jc && carry_q);
      ack_now    = (state_q == ST_FETCH && bus.instr_ack) || (state_q == ST_MEM && bus.ram_ack);
      next_instr = run ? ST_FETCH : ST_IDLE;
      case (state_q)
         ST_IDLE:   if (run) state_d = ST_FETCH;
         ST_FETCH: begin
            if (bus.instr_ack) begin
               instr_d = bus.instr_data;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            pc_d = taken ? PC_W'(imm) : pc_q + PC_W'(1);
            if (cls.is_alu) begin
               zero_d = alu_zero;
               if (alu_c_upd) carry_d = alu_c;
            end
            if (cls.is_ld || cls.is_st) state_d = ST_MEM;
            else if (cls.is_halt)       state_d = ST_HALT;
            else                        state_d = next_instr;
         end
         ST_MEM: begin
            if (bus.ram_ack) begin
               if (cls.is_ld) begin
                  rdata_d = bus.ram_rdata;
                  state_d = ST_WB;
               end else begin
                  state_d = next_instr;
               end
            end
         end
         ST_WB:   state_d = next_instr;
         default: state_d = state_q;
      endcase
`ifdef CPU_SEQ_WDOG_EN
      // Counts unanswered request cycles; the last one at full count faults.
      wdog_d = '0;
      if ((state_q == ST_FETCH || state_q == ST_MEM) && !ack_now) begin
         if (wdog_q == '1) state_d = ST_FAULT;
         else              wdog_d  = wdog_q + WDOG_W'(1);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         rdata_q <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         rdata_q <= rdata_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

`ifdef CPU_SEQ_WDOG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wdog_q <= '0;
      else      wdog_q <= wdog_d;
   end
   assign fault = (state_q == ST_FAULT);
`else
   assign fault = 1'b0;
`endif

   // Requests come straight from the state register so reset drops them at once.
   always_comb begin
      bus.instr_req = (state_q == ST_FETCH);
      bus.ram_req   = (state_q == ST_MEM);
      bus.ram_we    = (state_q == ST_MEM) && cls.is_st;
      bus.ram_addr  = (state_q == ST_MEM) ? imm : 8'h00;
      bus.ram_wdata = ((state_q == ST_MEM) && cls.is_st) ? ri_data : 8'h00;
      update        = ((state_q == ST_EXEC) && (cls.is_alu || cls.is_ldi)) || (state_q == ST_WB);
      wb_sel        = ((state_q == ST_EXEC) && cls.is_ldi) || (state_q == ST_WB);
      wb_imm        = (state_q == ST_WB) ? rdata_q :
                      ((state_q == ST_EXEC) && cls.is_ldi) ? imm : 8'h00;
   end

   assign pc        = pc_q;
   assign carry     = carry_q;
   assign halted    = (state_q == ST_HALT);
   assign state_dbg = state_q;
endmodule
